// File: rtl/alu_seq.sv
// Registered ALU: add/sub/inc/dec/logic in one cycle, iterative shifts and shift-add multiply.
// Latency: done 1 cycle after accept (shifts +min(B,WIDTH), mul +WIDTH); start is ignored while busy.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic             flags_c_val,
   output logic             flags_z_val,
   output logic             flags_n_val,
   output logic             flags_v_val
);

   localparam int SHW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] W_B     = WIDTH'(WIDTH);
   localparam logic [SHW-1:0]   W_CNT   = SHW'(WIDTH);
   localparam logic [SHW-1:0]   LAST    = SHW'(1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MUL   = 2'd2
   } state_t;

   state_t             state;
   logic               shl_r;
   logic [WIDTH-1:0]   sh_r;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // single-cycle datapath
   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     sub_w;
   logic [WIDTH:0]     inc_w;
   logic [WIDTH:0]     dec_w;
   logic [WIDTH-1:0]   s_res;
   logic               s_c;
   logic               s_v;

   assign add_w = {1'b0, A} + {1'b0, B};
   assign sub_w = {1'b0, A} - {1'b0, B};
   assign inc_w = {1'b0, A} + ONE_W;
   assign dec_w = {1'b0, A} - ONE_W;

   always_comb begin
      s_res = '0;
      s_c   = 1'b0;
      s_v   = 1'b0;
      case (operation)
         OP_ADD: begin
            s_res = add_w[WIDTH-1:0];
            s_c   = add_w[WIDTH];
            s_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            s_res = sub_w[WIDTH-1:0];
            s_c   = ~sub_w[WIDTH];
            s_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
         end
         OP_INC: begin
            s_res = inc_w[WIDTH-1:0];
            s_c   = inc_w[WIDTH];
            s_v   = (A == MAX_POS);
         end
         OP_DEC: begin
            s_res = dec_w[WIDTH-1:0];
            s_c   = ~dec_w[WIDTH];
            s_v   = (A == MIN_NEG);
         end
         OP_AND: s_res = A & B;
         OP_OR:  s_res = A | B;
         OP_XOR: s_res = A ^ B;
         OP_NOT: s_res = ~A;
         // only reached with B == 0: the operand passes through untouched
         OP_SHL, OP_SHR: s_res = A;
         default: s_res = '0;
      endcase
   end

   logic             is_shift;
   logic             is_mul;
   logic [SHW-1:0]   shift_cnt;

   assign is_shift  = ((operation == OP_SHL) || (operation == OP_SHR)) && (B != '0);
   assign is_mul    = (operation == OP_MUL);
   assign shift_cnt = (B >= W_B) ? W_CNT : B[SHW-1:0];

   // one iteration of the shift and multiply engines
   logic [WIDTH-1:0]   sh_next;
   logic               sh_out;
   logic [2*WIDTH-1:0] acc_next;

   assign sh_next  = shl_r ? {sh_r[WIDTH-2:0], 1'b0} : {1'b0, sh_r[WIDTH-1:1]};
   assign sh_out   = shl_r ? sh_r[WIDTH-1] : sh_r[0];
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   // completion mux: the one place result and flags come from
   logic             fin;
   logic [WIDTH-1:0] fin_res;
   logic             fin_c;
   logic             fin_v;

   always_comb begin
      fin     = 1'b0;
      fin_res = '0;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      case (state)
         IDLE: begin
            fin     = start && !is_shift && !is_mul;
            fin_res = s_res;
            fin_c   = s_c;
            fin_v   = s_v;
         end
         SHIFT: begin
            fin     = (cnt == LAST);
            fin_res = sh_next;
            fin_c   = sh_out;
         end
         MUL: begin
            fin     = (cnt == LAST);
            fin_res = acc_next[WIDTH-1:0];
            fin_c   = (acc_next[2*WIDTH-1:WIDTH] != '0);
            fin_v   = (acc_next[2*WIDTH-1:WIDTH] != '0);
         end
         default: fin = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         C           <= '0;
         flags_c_val <= 1'b0;
         flags_z_val <= 1'b0;
         flags_n_val <= 1'b0;
         flags_v_val <= 1'b0;
         shl_r       <= 1'b0;
         sh_r        <= '0;
         cnt         <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
      end else begin
         done <= 1'b0;
         if (fin) begin
            C           <= fin_res;
            flags_c_val <= fin_c;
            flags_z_val <= (fin_res == '0);
            flags_n_val <= fin_res[WIDTH-1];
            flags_v_val <= fin_v;
            done        <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start && is_shift) begin
                  sh_r  <= A;
                  shl_r <= (operation == OP_SHL);
                  cnt   <= shift_cnt;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else if (start && is_mul) begin
                  acc    <= '0;
                  mcand  <= {{WIDTH{1'b0}}, A};
                  mplier <= B;
                  cnt    <= W_CNT;
                  busy   <= 1'b1;
                  state  <= MUL;
               end
            end
            SHIFT: begin
               sh_r <= sh_next;
               cnt  <= cnt - LAST;
               if (fin) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
               mplier <= {1'b0, mplier[WIDTH-1:1]};
               cnt    <= cnt - LAST;
               if (fin) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
// Drivers push expected results; one monitor pops and compares on every done pulse.
module tb_alu_seq;

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic        rst8, start8, busy8, done8, fc8, fz8, fn8, fv8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, c8;
   logic        rst16, start16, busy16, done16, fc16, fz16, fn16, fv16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, c16;

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .operation(op8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .C(c8),
      .flags_c_val(fc8), .flags_z_val(fz8), .flags_n_val(fn8), .flags_v_val(fv8)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst16), .start(start16), .operation(op16), .A(a16), .B(b16),
      .busy(busy16), .done(done16), .C(c16),
      .flags_c_val(fc16), .flags_z_val(fz16), .flags_n_val(fn16), .flags_v_val(fv16)
   );

   typedef struct {
      logic [31:0] res;
      logic        c, z, n, v;
      int          busy_cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   exp_t last8, last16;
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t model(input int w, input logic [3:0] op,
                                  input logic [31:0] a_in, input logic [31:0] b_in);
      exp_t e;
      longint unsigned mask, a, b, r, p;
      int k;
      logic sa, sb;
      mask = (64'd1 << w) - 64'd1;
      a = {32'd0, a_in} & mask;
      b = {32'd0, b_in} & mask;
      sa = a[w-1];
      sb = b[w-1];
      e.c = 1'b0;
      e.v = 1'b0;
      e.busy_cyc = 0;
      r = 0;
      case (op)
         4'd0: begin r = a + b; e.c = r[w]; r = r & mask; e.v = (sa == sb) && (r[w-1] != sa); end
         4'd1: begin e.c = (a >= b); r = (a - b) & mask; e.v = (sa != sb) && (r[w-1] != sa); end
         4'd2: begin r = a + 1; e.c = r[w]; r = r & mask; e.v = (a == (mask >> 1)); end
         4'd3: begin e.c = (a != 0); r = (a - 1) & mask; e.v = (a == (64'd1 << (w-1))); end
         4'd4: r = a & b;
         4'd5: r = a | b;
         4'd6: r = a ^ b;
         4'd7: r = ~a & mask;
         4'd8, 4'd9: begin
            k = (b >= 64'(w)) ? w : int'(b);
            e.busy_cyc = k;
            if (k == 0) r = a;
            else if (op == 4'd8) begin r = (a << k) & mask; e.c = a[w-k]; end
            else begin r = a >> k; e.c = a[k-1]; end
         end
         4'd10: begin
            p = a * b;
            r = p & mask;
            e.c = ((p >> w) != 0);
            e.v = e.c;
            e.busy_cyc = w;
         end
         default: r = 0;
      endcase
      e.res = r[31:0];
      e.z = (r == 0);
      e.n = r[w-1];
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.res = 0; e.c = 0; e.z = 0; e.n = 0; e.v = 0; e.busy_cyc = 0;
      return e;
   endfunction

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         checks++;
         if (busy8) begin errors++; $display("FAIL done_while_busy8 busy=%b required 0", busy8); end
         checks++;
         if (q8.size() == 0) begin
            errors++; $display("FAIL unexpected_done8 got done with no op outstanding");
         end else begin
            e = q8.pop_front();
            if (c8 !== e.res[7:0] || fc8 !== e.c || fz8 !== e.z || fn8 !== e.n || fv8 !== e.v) begin
               errors++;
               $display("FAIL result8 got C=%h czvn=%b%b%b%b required C=%h czvn=%b%b%b%b",
                        c8, fc8, fz8, fv8, fn8, e.res[7:0], e.c, e.z, e.v, e.n);
            end
         end
      end
      if (done16) begin
         checks++;
         if (busy16) begin errors++; $display("FAIL done_while_busy16 busy=%b required 0", busy16); end
         checks++;
         if (q16.size() == 0) begin
            errors++; $display("FAIL unexpected_done16 got done with no op outstanding");
         end else begin
            e = q16.pop_front();
            if (c16 !== e.res[15:0] || fc16 !== e.c || fz16 !== e.z || fn16 !== e.n || fv16 !== e.v) begin
               errors++;
               $display("FAIL result16 got C=%h czvn=%b%b%b%b required C=%h czvn=%b%b%b%b",
                        c16, fc16, fz16, fv16, fn16, e.res[15:0], e.c, e.z, e.v, e.n);
            end
         end
      end
   end

   task automatic drive(input int w, input logic s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (w == 8) begin start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      else begin start16 = s; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
   endtask

   function automatic logic get_done(input int w);
      return (w == 8) ? done8 : done16;
   endfunction

   function automatic logic get_busy(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction

   // caller sits at a negedge; returns at the negedge where done is seen,
   // so the next call lands in the done cycle (back-to-back start)
   task automatic run(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int bc, cyc;
      e = model(w, op, a, b);
      if (w == 8) q8.push_back(e); else q16.push_back(e);
      drive(w, 1'b1, op, a, b);
      @(negedge clk);
      drive(w, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
      bc = 0;
      cyc = 0;
      while (!get_done(w) && cyc < 100) begin
         if (get_busy(w)) bc++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!get_done(w)) begin
         errors++; $display("FAIL timeout%0d op=%0d no done within 100 cycles", w, op);
      end else if (bc != e.busy_cyc) begin
         errors++; $display("FAIL busy_cycles%0d op=%0d got %0d required %0d", w, op, bc, e.busy_cyc);
      end
      if (w == 8) last8 = e; else last16 = e;
   endtask

   task automatic hold(input int w, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         drive(w, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
         @(negedge clk);
         checks++;
         if (w == 8) begin
            e = last8;
            if (c8 !== e.res[7:0] || fc8 !== e.c || fz8 !== e.z || fn8 !== e.n || fv8 !== e.v || done8 !== 1'b0) begin
               errors++; $display("FAIL hold8 got C=%h done=%b required C=%h done=0", c8, done8, e.res[7:0]);
            end
         end else begin
            e = last16;
            if (c16 !== e.res[15:0] || fc16 !== e.c || fz16 !== e.z || fn16 !== e.n || fv16 !== e.v || done16 !== 1'b0) begin
               errors++; $display("FAIL hold16 got C=%h done=%b required C=%h done=0", c16, done16, e.res[15:0]);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int bc, cyc;
      logic [3:0] op;
      logic [31:0] b;

      rst8 = 1'b1; rst16 = 1'b1;
      drive(8, 1'b0, 4'd0, 0, 0);
      drive(16, 1'b0, 4'd0, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if ({c8, fc8, fz8, fn8, fv8, busy8, done8} !== '0) begin
         errors++; $display("FAIL reset8 got C=%h flags/busy/done=%b required all 0", c8, {fc8, fz8, fn8, fv8, busy8, done8});
      end
      checks++;
      if ({c16, fc16, fz16, fn16, fv16, busy16, done16} !== '0) begin
         errors++; $display("FAIL reset16 got C=%h flags/busy/done=%b required all 0", c16, {fc16, fz16, fn16, fv16, busy16, done16});
      end
      rst8 = 1'b0; rst16 = 1'b0;
      last8 = zero_exp();
      last16 = zero_exp();
      hold(8, 2);

      // directed corner cases
      run(8, 4'd0, 32'hFF, 32'h01);
      run(8, 4'd0, 32'h7F, 32'h01);
      run(8, 4'd1, 32'h80, 32'h01);
      run(8, 4'd1, 32'h00, 32'h01);
      run(8, 4'd3, 32'h00, 32'h00);
      run(8, 4'd3, 32'h80, 32'h00);
      run(8, 4'd2, 32'h7F, 32'h00);
      run(8, 4'd2, 32'hFF, 32'h00);
      run(8, 4'd10, 32'd13, 32'd11);
      run(8, 4'd10, 32'h10, 32'h10);
      run(8, 4'd8, 32'h81, 32'd1);
      run(8, 4'd9, 32'h5A, 32'd0);
      run(8, 4'd8, 32'h01, 32'd9);
      run(8, 4'd9, 32'h80, 32'd8);
      run(8, 4'd9, 32'hB3, 32'd3);
      run(8, 4'd7, 32'h0F, 32'h00);
      run(8, 4'd12, 32'hFF, 32'hFF);
      hold(8, 3);

      // start and operand changes while a multiply is in flight are ignored
      e = model(8, 4'd10, 32'd13, 32'd11);
      q8.push_back(e);
      drive(8, 1'b1, 4'd10, 32'd13, 32'd11);
      @(negedge clk);
      bc = 0;
      cyc = 0;
      while (!done8 && cyc < 100) begin
         if (busy8) bc++;
         drive(8, (cyc == 2 || cyc == 5), (cyc == 2) ? 4'd0 : 4'($urandom_range(0, 15)), $urandom, $urandom);
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done8 || bc != 8) begin
         errors++; $display("FAIL mul_ignore_start done=%b busy_cycles=%0d required done=1 busy_cycles=8", done8, bc);
      end
      last8 = e;
      run(8, 4'd0, 32'h22, 32'h33);

      // reset in the middle of a multiply aborts it without a done
      e = model(8, 4'd10, 32'hFF, 32'hFF);
      q8.push_back(e);
      drive(8, 1'b1, 4'd10, 32'hFF, 32'hFF);
      @(negedge clk);
      drive(8, 1'b0, 4'd0, 0, 0);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      checks++;
      if ({c8, fc8, fz8, fn8, fv8, busy8, done8} !== '0) begin
         errors++; $display("FAIL reset_mid_mul got C=%h flags/busy/done=%b required all 0", c8, {fc8, fz8, fn8, fv8, busy8, done8});
      end
      q8.delete();
      rst8 = 1'b0;
      last8 = zero_exp();
      hold(8, 2);
      run(8, 4'd4, 32'hF0, 32'h3C);

      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         b = $urandom;
         if (op == 4'd8 || op == 4'd9) b = (i % 5 == 0) ? $urandom : $urandom_range(0, 10);
         run(8, op, $urandom, b);
         if (i % 9 == 0) hold(8, 1);
      end

      run(16, 4'd0, 32'hFFFF, 32'h0001);
      run(16, 4'd0, 32'h7FFF, 32'h0001);
      run(16, 4'd10, 32'hFFFF, 32'hFFFF);
      run(16, 4'd8, 32'h8001, 32'd20);
      run(16, 4'd9, 32'h8001, 32'd15);
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         b = $urandom;
         if (op == 4'd8 || op == 4'd9) b = $urandom_range(0, 20);
         run(16, op, $urandom, b);
      end
      hold(16, 2);

      repeat (3) @(negedge clk);
      checks++;
      if (q8.size() != 0 || q16.size() != 0) begin
         errors++; $display("FAIL drain outstanding=%0d/%0d required 0/0", q8.size(), q16.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the CPU's 8-bit combinational ALU. It takes WIDTH-bit operands and adds logical operations, barrel-free iterative shifts and an iterative shift-add multiplier. It uses a start/busy/done handshake, and registers result and flags (C, Z, N, V) that hold until the next completed operation. It sits between the register file and the flags register in the execute stage; the controller stalls on busy.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2)
SHW, $clog2(WIDTH)+1, internal width of shift/multiply iteration counter (derived, not to be overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when busy=0
operation  in  4  opcode, sampled at acceptance
A  in  WIDTH  operand A, sampled at acceptance
B  in  WIDTH  operand B / shift amount, sampled at acceptance
busy  out  1  high while a multi-cycle op is in flight
done  out  1  one-cycle pulse: result/flags updated this cycle
C  out  WIDTH  registered result
flags_c_val  out  1  carry / NOT borrow (sub, dec) / high-half-nonzero (mul) / last bit out (shift)
flags_z_val  out  1  zero: result == 0
flags_n_val  out  1  negative: result[WIDTH-1]
flags_v_val  out  1  signed overflow

Behaviour:
- Opcodes: 0 add, 1 sub, 2 inc, 3 dec, 4 and, 5 or, 6 xor, 7 not (~A), 8 shl, 9 shr (logical), 10 mul, 11-15 undefined.
- Reset (takes priority over everything): C=0, all flags 0, busy=0, done=0, state IDLE. Reset mid-operation aborts it; no done is produced.
- States: IDLE, SHIFT, MUL.
- IDLE, start=1: operands and opcode are captured.
  - Single-cycle ops (0-7, 11-15, and shl/shr with B=0): C and flags written at the accepting edge. done=1 in the following cycle. busy stays 0.
  - shl/shr with B != 0: go to SHIFT. Count = min(B, WIDTH). busy=1.
  - mul: go to MUL. Count = WIDTH. busy=1.
- SHIFT: one bit per cycle. C/flags are written at the edge that finishes the last iteration. Total busy = min(B, WIDTH) cycles. done=1 and busy=0 in the cycle after the final edge; return to IDLE.
- MUL: shift-add over a 2*WIDTH-bit product, one multiplier bit per cycle, WIDTH cycles busy, then done as for SHIFT.
- done is high for exactly one cycle per accepted op and never while busy=1. Back-to-back start in the done cycle is accepted.
- start while busy=1 is ignored. Operand/opcode changes while busy have no effect.
- C and flags change only at op completion and hold otherwise.
- Arithmetic and flags (Z = result==0 and N = MSB for all ops):
  - add: {c,C} = A+B. V = (A,B same sign) & (C sign differs).
  - sub: C = A-B. flags_c_val = NOT borrow (1 when A >= B unsigned). V = (A,B signs differ) & (C sign != A sign).
  - inc: A+1. C = carry out. V = 1 iff A = 0111..1.
  - dec: A-1. C = NOT borrow (0 only when A=0). V = 1 iff A = 100..0.
  - and/or/xor/not: C=0, V=0.
  - shl/shr: flags_c_val = last bit shifted out (0 when B=0), V=0. For B >= WIDTH the result is 0; shl carry is original A[0], shr carry is original A[WIDTH-1].
  - mul: C = low WIDTH bits of A*B (unsigned). flags_c_val = V = (high WIDTH bits != 0).
  - undefined opcodes: C=0, Z=1, other flags 0.

Test Plan:
1. WIDTH=8, add A=0xFF B=0x01, start 1 cycle -> next cycle done=1, C=0x00, c=1 z=1 n=0 v=0, busy never high. Add 0x7F+0x01 -> C=0x80, c=0, n=1, v=1.
2. sub A=0x80 B=0x01 -> C=0x7F, c=1, v=1, n=0. sub 0x00-0x01 -> C=0xFF, c=0, n=1, v=0. dec 0x00 -> 0xFF, c=0.
3. mul 13*11 -> busy for 8 cycles, then done, C=0x8F, c=0, v=0, n=1. mul 0x10*0x10 -> C=0x00, c=1, v=1, z=1.
4. shl A=0x81 B=1 -> busy 1 cycle, C=0x02, c=1. shr B=0 -> single-cycle, C=A, c=0. shl A=0x01 B=9 -> busy 8 cycles, C=0x00, c=1, z=1.
5. During mul, pulse start with add and change A/B -> ignored; mul result unchanged; exactly one done. Start add in the mul's done cycle -> accepted, done next cycle.
6. Assert rst mid-mul (cycle 4) -> next cycle all outputs 0, no done. Then and 0xF0&0x3C -> C=0x30, c=0, v=0. WIDTH=16 repeat of scenario 1 with 0xFFFF+1 -> C=0, c=1.
